mem_fabric: RTL and testbench

Parametrised N-to-1 memory request fabric between multiple SRAM clients (screen refresh, CPU, loaders) and the single `MEM` controller port. Arbitrates per-channel valid/grant requests onto the downstream request channel, records the issuing channel of every read in an in-order tag queue, and steers downstream read responses back to the matching client. It replaces the tied-off request fields at the chip top and supports round-robin or fixed-priority arbitration.

---
 rtl/mem_fabric_pkg.sv | 16 +
 rtl/mem_fabric_tagq.sv | 48 ++++
 rtl/mem_fabric.sv | 139 +++++++++++++
 tb/tb_mem_fabric.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fabric_pkg.sv
// Shared types and helpers for the memory request fabric.
// No logic, only declarations.
// Imported by the fabric top and its tag queue.
package mem_fabric_pkg;

  typedef enum logic [0:0] {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Width of a channel index, never narrower than one bit.
  function automatic int chan_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_fabric_tagq.sv
// In-order queue of issuing-channel tags for outstanding reads.
// Latency: a pushed tag is visible at head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
module mem_fabric_tagq
  import mem_fabric_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wptr;
  logic [PW:0]  rptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Tag storage; contents are don't-care once the pointers are flushed.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[PW-1:0]] <= push_dat;
  end

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (count == (PW+1)'(DEPTH));
  assign head  = mem[rptr[PW-1:0]];

endmodule

// File: rtl/mem_fabric.sv
// N-to-1 SRAM request arbiter with in-order read-response steering back to clients.
// Latency: request and response paths are both combinational (0 cycles).
// Backpressure: a stalled winner is locked until MEM accepts; reads stall when the tag queue is full.
module mem_fabric
  import mem_fabric_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int AW        = 21,
  parameter int DW        = 32,
  parameter int ORD_DEPTH = 4,
  parameter int ARB_MODE  = 0,
  localparam int SW       = DW / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NCH-1:0]                up_req_vld,
  input  logic [NCH-1:0][AW-1:0]        up_req_addr,
  input  logic [NCH-1:0]                up_req_wr,
  input  logic [NCH-1:0][SW-1:0]        up_req_dat_strb,
  input  logic [NCH-1:0][DW-1:0]        up_req_dat,
  output logic [NCH-1:0]                up_req_gnt,
  output logic [NCH-1:0]                up_rsp_vld,
  output logic [DW-1:0]                 up_rsp_dat,
  input  logic [NCH-1:0]                up_rsp_gnt,
  output logic                          dn_req_vld,
  output logic [AW-1:0]                 dn_req_addr,
  output logic                          dn_req_wr,
  output logic [SW-1:0]                 dn_req_dat_strb,
  output logic [DW-1:0]                 dn_req_dat,
  input  logic                          dn_req_gnt,
  input  logic                          dn_rsp_vld,
  input  logic [DW-1:0]                 dn_rsp_dat,
  output logic                          dn_rsp_gnt,
  output logic [$clog2(ORD_DEPTH):0]    outstanding,
  output logic                          err_orphan
);

  localparam int CW    = chan_idx_w(NCH);
  localparam bit FIXED = (ARB_MODE == int'(ARB_FIXED));

  logic [CW-1:0]  rr_ptr;
  logic           lock;
  logic [CW-1:0]  lock_ch;
  logic [NCH-1:0] elig;
  logic [CW-1:0]  rr_win;
  logic [CW-1:0]  fx_win;
  logic [CW-1:0]  win;
  logic [CW-1:0]  win_next;
  logic           xfer;
  logic           q_full;
  logic           q_empty;
  logic [CW-1:0]  q_head;
  logic           q_push;
  logic           q_pop;

  // A channel may compete if it is a write, or a read with a free tag slot.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NCH; i++) begin
      elig[i] = up_req_vld[i] && (up_req_wr[i] || !q_full);
    end
  end

  // Candidate winners for both policies; the lock overrides either.
  always_comb begin
    rr_win = rr_ptr;
    fx_win = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr) + k) % NCH]) rr_win = CW'((int'(rr_ptr) + k) % NCH);
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) fx_win = CW'(i);
    end
    win = lock ? lock_ch : (FIXED ? fx_win : rr_win);
  end

  assign dn_req_vld      = |elig;
  assign dn_req_addr     = up_req_addr[win];
  assign dn_req_wr       = up_req_wr[win];
  assign dn_req_dat_strb = up_req_dat_strb[win];
  assign dn_req_dat      = up_req_dat[win];
  assign xfer            = dn_req_vld && dn_req_gnt;
  assign up_req_gnt      = xfer ? (NCH'(1) << win) : '0;
  assign win_next        = (win == CW'(NCH - 1)) ? '0 : win + 1'b1;
  assign q_push          = xfer && !up_req_wr[win];

  // Arbitration state: round-robin pointer and stall lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      lock    <= 1'b0;
      lock_ch <= '0;
    end else begin
      if (xfer) begin
        lock <= 1'b0;
        if (!FIXED) rr_ptr <= win_next;
      end else if (dn_req_vld) begin
        lock    <= 1'b1;
        lock_ch <= win;
      end
    end
  end

  // Route each response to the channel at the head of the tag queue.
  always_comb begin
    up_rsp_vld = '0;
    dn_rsp_gnt = 1'b1;
    q_pop      = 1'b0;
    if (!q_empty) begin
      up_rsp_vld[q_head] = dn_rsp_vld;
      dn_rsp_gnt         = up_rsp_gnt[q_head];
      q_pop              = dn_rsp_vld && up_rsp_gnt[q_head];
    end
  end

  assign up_rsp_dat = dn_rsp_dat;

  // Sticky flag for responses with no matching outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_orphan <= 1'b0;
    else if (q_empty && dn_rsp_vld) err_orphan <= 1'b1;
  end

  mem_fabric_tagq #(
    .DEPTH (ORD_DEPTH),
    .W     (CW)
  ) u_tagq (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .push_dat (win),
    .pop      (q_pop),
    .full     (q_full),
    .empty    (q_empty),
    .count    (outstanding),
    .head     (q_head)
  );

endmodule

// File: tb/tb_mem_fabric.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
// A round-robin instance is the main target; a fixed-priority instance shares its inputs.
// Inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
module tb_mem_fabric;

  localparam int NCH = 4, AW = 21, DW = 32, SW = 4, DEPTH = 4, OW = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0]           up_req_vld, up_req_wr, up_rsp_gnt;
  logic [NCH-1:0][AW-1:0]   up_req_addr;
  logic [NCH-1:0][SW-1:0]   up_req_dat_strb;
  logic [NCH-1:0][DW-1:0]   up_req_dat;
  logic                     dn_req_gnt, dn_rsp_vld;
  logic [DW-1:0]            dn_rsp_dat;

  logic [NCH-1:0] up_req_gnt, up_rsp_vld, up_req_gnt_f, up_rsp_vld_f;
  logic [DW-1:0]  up_rsp_dat, up_rsp_dat_f, dn_req_dat, dn_req_dat_f;
  logic           dn_req_vld, dn_req_wr, dn_rsp_gnt, err_orphan;
  logic           dn_req_vld_f, dn_req_wr_f, dn_rsp_gnt_f, err_orphan_f;
  logic [AW-1:0]  dn_req_addr, dn_req_addr_f;
  logic [SW-1:0]  dn_req_dat_strb, dn_req_dat_strb_f;
  logic [OW-1:0]  outstanding, outstanding_f;

  int checks = 0;
  int errors = 0;

  // Reference model state (round-robin instance).
  int m_q[$];
  int m_rr;
  int m_lock;

  always #5 clk = ~clk;

  mem_fabric #(.NCH(NCH), .AW(AW), .DW(DW), .ORD_DEPTH(DEPTH), .ARB_MODE(0)) dut (
    .clk(clk), .rst(rst), .up_req_vld(up_req_vld), .up_req_addr(up_req_addr), .up_req_wr(up_req_wr),
    .up_req_dat_strb(up_req_dat_strb), .up_req_dat(up_req_dat), .up_req_gnt(up_req_gnt),
    .up_rsp_vld(up_rsp_vld), .up_rsp_dat(up_rsp_dat), .up_rsp_gnt(up_rsp_gnt),
    .dn_req_vld(dn_req_vld), .dn_req_addr(dn_req_addr), .dn_req_wr(dn_req_wr),
    .dn_req_dat_strb(dn_req_dat_strb), .dn_req_dat(dn_req_dat), .dn_req_gnt(dn_req_gnt),
    .dn_rsp_vld(dn_rsp_vld), .dn_rsp_dat(dn_rsp_dat), .dn_rsp_gnt(dn_rsp_gnt),
    .outstanding(outstanding), .err_orphan(err_orphan));

  mem_fabric #(.NCH(NCH), .AW(AW), .DW(DW), .ORD_DEPTH(DEPTH), .ARB_MODE(1)) dut_f (
    .clk(clk), .rst(rst), .up_req_vld(up_req_vld), .up_req_addr(up_req_addr), .up_req_wr(up_req_wr),
    .up_req_dat_strb(up_req_dat_strb), .up_req_dat(up_req_dat), .up_req_gnt(up_req_gnt_f),
    .up_rsp_vld(up_rsp_vld_f), .up_rsp_dat(up_rsp_dat_f), .up_rsp_gnt(up_rsp_gnt),
    .dn_req_vld(dn_req_vld_f), .dn_req_addr(dn_req_addr_f), .dn_req_wr(dn_req_wr_f),
    .dn_req_dat_strb(dn_req_dat_strb_f), .dn_req_dat(dn_req_dat_f), .dn_req_gnt(dn_req_gnt),
    .dn_rsp_vld(dn_rsp_vld), .dn_rsp_dat(dn_rsp_dat), .dn_rsp_gnt(dn_rsp_gnt_f),
    .outstanding(outstanding_f), .err_orphan(err_orphan_f));

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    up_req_vld = '0; up_req_wr = '0; up_req_addr = '0; up_req_dat_strb = '0; up_req_dat = '0;
    up_rsp_gnt = '0; dn_req_gnt = 1'b0; dn_rsp_vld = 1'b0; dn_rsp_dat = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    m_q.delete();
    m_rr = 0;
    m_lock = -1;
  endtask

  // Expected round-robin winner from the arbitration rules, -1 if nobody may go.
  function automatic int model_winner();
    if (m_lock >= 0) return m_lock;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_rr + k) % NCH;
      if (up_req_vld[c] && (up_req_wr[c] || m_q.size() < DEPTH)) return c;
    end
    return -1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    checks++; if (dn_req_vld !== 1'b0) begin errors++; $display("FAIL reset dn_req_vld got %b exp 0", dn_req_vld); end
    checks++; if (up_req_gnt !== '0) begin errors++; $display("FAIL reset up_req_gnt got %b exp 0", up_req_gnt); end
    checks++; if (up_rsp_vld !== '0) begin errors++; $display("FAIL reset up_rsp_vld got %b exp 0", up_rsp_vld); end
    checks++; if (dn_rsp_gnt !== 1'b1) begin errors++; $display("FAIL reset dn_rsp_gnt got %b exp 1", dn_rsp_gnt); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL reset outstanding got %0d exp 0", outstanding); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset err_orphan got %b exp 0", err_orphan); end
    checks++; if (dn_req_addr !== '0 || dn_req_dat !== '0 || dn_req_wr !== 1'b0 || dn_req_dat_strb !== '0)
      begin errors++; $display("FAIL reset dn_req_fields got %h/%h/%b/%h exp 0", dn_req_addr, dn_req_dat, dn_req_wr, dn_req_dat_strb); end
    checks++; if (up_rsp_dat !== '0) begin errors++; $display("FAIL reset up_rsp_dat got %h exp 0", up_rsp_dat); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_rr_fair;
    logic [NCH-1:0] e;
    do_reset();
    for (int c = 0; c < NCH; c++) up_req_addr[c] = AW'(32'h100 + c);
    dn_req_gnt = 1'b1;
    up_rsp_gnt = '1;
    for (int k = 0; k < 9; k++) begin
      up_req_vld = (k < 8) ? '1 : '0;
      dn_rsp_vld = (k > 0);
      dn_rsp_dat = DW'(32'hA000 + k);
      @(negedge clk);
      if (k < 8) begin
        e = NCH'(1) << (k % NCH);
        checks++; if (up_req_gnt !== e) begin errors++; $display("FAIL rr_gnt k=%0d got %b exp %b", k, up_req_gnt, e); end
        checks++; if (dn_req_addr !== AW'(32'h100 + k % NCH)) begin errors++; $display("FAIL rr_addr k=%0d got %h exp %h", k, dn_req_addr, 32'h100 + k % NCH); end
      end
      if (k > 0) begin
        e = NCH'(1) << ((k - 1) % NCH);
        checks++; if (up_rsp_vld !== e) begin errors++; $display("FAIL rr_rsp k=%0d got %b exp %b", k, up_rsp_vld, e); end
        checks++; if (up_rsp_dat !== DW'(32'hA000 + k)) begin errors++; $display("FAIL rr_rsp_dat k=%0d got %h exp %h", k, up_rsp_dat, 32'hA000 + k); end
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL rr_drain outstanding got %0d exp 0", outstanding); end
    next_cycle();
  endtask

  task automatic test_lock;
    do_reset();
    up_req_addr[2] = AW'(32'h12345);
    up_req_addr[0] = AW'(32'h00777);
    up_req_vld = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (dn_req_vld !== 1'b1 || dn_req_addr !== AW'(32'h12345) || up_req_gnt !== '0)
        begin errors++; $display("FAIL lock_hold k=%0d got vld=%b addr=%h gnt=%b exp 1/12345/0000", k, dn_req_vld, dn_req_addr, up_req_gnt); end
      next_cycle();
    end
    up_req_vld = 4'b0101;
    @(negedge clk);
    checks++; if (dn_req_addr !== AW'(32'h12345)) begin errors++; $display("FAIL lock_keep addr got %h exp 12345", dn_req_addr); end
    next_cycle();
    dn_req_gnt = 1'b1;
    @(negedge clk);
    checks++; if (up_req_gnt !== 4'b0100) begin errors++; $display("FAIL lock_gnt got %b exp 0100", up_req_gnt); end
    next_cycle();
    up_req_vld = 4'b0001;
    @(negedge clk);
    checks++; if (up_req_gnt !== 4'b0001 || dn_req_addr !== AW'(32'h00777))
      begin errors++; $display("FAIL lock_after got gnt=%b addr=%h exp 0001/777", up_req_gnt, dn_req_addr); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_qfull;
    int grants;
    grants = 0;
    do_reset();
    up_req_vld = 4'b0010;
    dn_req_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (up_req_gnt[1]) grants++;
      next_cycle();
    end
    @(negedge clk);
    checks++; if (grants !== 4) begin errors++; $display("FAIL qfull grants got %0d exp 4", grants); end
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL qfull outstanding got %0d exp 4", outstanding); end
    checks++; if (dn_req_vld !== 1'b0) begin errors++; $display("FAIL qfull dn_req_vld got %b exp 0", dn_req_vld); end
    next_cycle();
    up_req_vld = 4'b1010;
    up_req_wr = 4'b1000;
    up_req_addr[3] = AW'(32'h1ABCD);
    @(negedge clk);
    checks++; if (up_req_gnt !== 4'b1000 || dn_req_wr !== 1'b1 || dn_req_addr !== AW'(32'h1ABCD))
      begin errors++; $display("FAIL qfull_write got gnt=%b wr=%b addr=%h exp 1000/1/1abcd", up_req_gnt, dn_req_wr, dn_req_addr); end
    next_cycle();
    @(negedge clk);
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL qfull_after_write outstanding got %0d exp 4", outstanding); end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_backpressure;
    do_reset();
    dn_req_gnt = 1'b1;
    up_req_vld = 4'b0001; next_cycle();
    up_req_vld = 4'b0010; next_cycle();
    up_req_vld = '0; dn_req_gnt = 1'b0;
    dn_rsp_vld = 1'b1; dn_rsp_dat = 32'hBEEF0001;
    up_rsp_gnt = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (dn_rsp_gnt !== 1'b0 || up_rsp_vld !== 4'b0001 || outstanding !== 3'd2)
        begin errors++; $display("FAIL bp_stall k=%0d got gnt=%b vld=%b out=%0d exp 0/0001/2", k, dn_rsp_gnt, up_rsp_vld, outstanding); end
      next_cycle();
    end
    up_rsp_gnt = 4'b0001;
    @(negedge clk);
    checks++; if (dn_rsp_gnt !== 1'b1 || up_rsp_vld !== 4'b0001) begin errors++; $display("FAIL bp_ch0 got gnt=%b vld=%b exp 1/0001", dn_rsp_gnt, up_rsp_vld); end
    next_cycle();
    @(negedge clk);
    checks++; if (dn_rsp_gnt !== 1'b0 || up_rsp_vld !== 4'b0010) begin errors++; $display("FAIL bp_ch1_wait got gnt=%b vld=%b exp 0/0010", dn_rsp_gnt, up_rsp_vld); end
    next_cycle();
    up_rsp_gnt = 4'b0010;
    @(negedge clk);
    checks++; if (dn_rsp_gnt !== 1'b1) begin errors++; $display("FAIL bp_ch1 got gnt=%b exp 1", dn_rsp_gnt); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (outstanding !== '0 || err_orphan !== 1'b0) begin errors++; $display("FAIL bp_end got out=%0d orphan=%b exp 0/0", outstanding, err_orphan); end
    next_cycle();
  endtask

  task automatic test_orphan_reset;
    do_reset();
    dn_rsp_vld = 1'b1;
    @(negedge clk);
    checks++; if (dn_rsp_gnt !== 1'b1 || up_rsp_vld !== '0 || err_orphan !== 1'b0)
      begin errors++; $display("FAIL orphan_cycle got gnt=%b vld=%b err=%b exp 1/0000/0", dn_rsp_gnt, up_rsp_vld, err_orphan); end
    next_cycle();
    dn_rsp_vld = 1'b0;
    @(negedge clk);
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set got %b exp 1", err_orphan); end
    next_cycle();
    @(negedge clk);
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky got %b exp 1", err_orphan); end
    next_cycle();
    dn_req_gnt = 1'b1;
    up_req_vld = 4'b0001; next_cycle();
    up_req_vld = 4'b0010; next_cycle();
    up_req_vld = '0;
    @(negedge clk);
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL orphan_pre outstanding got %0d exp 2", outstanding); end
    rst = 1'b1;
    #1;
    checks++; if (outstanding !== '0 || err_orphan !== 1'b0) begin errors++; $display("FAIL async_reset got out=%0d err=%b exp 0/0", outstanding, err_orphan); end
    next_cycle();
    rst = 1'b0;
    up_req_vld = '1; up_req_wr = '1;
    @(negedge clk);
    checks++; if (up_req_gnt !== 4'b0001) begin errors++; $display("FAIL reset_rr_ptr got %b exp 0001", up_req_gnt); end
    next_cycle();
    up_req_vld = '0; dn_req_gnt = 1'b0;
    dn_rsp_vld = 1'b1;
    next_cycle();
    dn_rsp_vld = 1'b0;
    @(negedge clk);
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_after_reset got %b exp 1", err_orphan); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_fixed;
    do_reset();
    up_req_addr[0] = AW'(32'h00010);
    up_req_addr[3] = AW'(32'h00013);
    up_req_vld = 4'b1001;
    up_req_wr = 4'b1001;
    dn_req_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (up_req_gnt_f !== 4'b0001) begin errors++; $display("FAIL fixed_prio k=%0d got %b exp 0001", k, up_req_gnt_f); end
      checks++; if (up_req_gnt !== ((k % 2 == 0) ? 4'b0001 : 4'b1000)) begin errors++; $display("FAIL rr_alt k=%0d got %b", k, up_req_gnt); end
      next_cycle();
    end
    up_req_vld = 4'b1000;
    @(negedge clk);
    checks++; if (up_req_gnt_f !== 4'b1000 || dn_req_addr_f !== AW'(32'h00013))
      begin errors++; $display("FAIL fixed_low got gnt=%b addr=%h exp 1000/13", up_req_gnt_f, dn_req_addr_f); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_random;
    logic [NCH-1:0] pend, e_gnt, e_rsp;
    int w, h;
    logic e_rgnt;
    pend = '0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!pend[c] && $urandom_range(0, 1) == 1) begin
          pend[c] = 1'b1;
          up_req_wr[c] = ($urandom_range(0, 2) == 0);
          up_req_addr[c] = AW'($urandom);
          up_req_dat[c] = $urandom;
          up_req_dat_strb[c] = SW'($urandom);
        end
      end
      up_req_vld = pend;
      dn_req_gnt = ($urandom_range(0, 3) != 0);
      dn_rsp_vld = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      dn_rsp_dat = $urandom;
      up_rsp_gnt = NCH'($urandom);
      @(negedge clk);
      w = model_winner();
      e_gnt = (w >= 0 && dn_req_gnt) ? (NCH'(1) << w) : '0;
      checks++; if (dn_req_vld !== (w >= 0)) begin errors++; $display("FAIL rand_vld cyc=%0d got %b exp %b", cyc, dn_req_vld, w >= 0); end
      checks++; if (up_req_gnt !== e_gnt) begin errors++; $display("FAIL rand_gnt cyc=%0d got %b exp %b", cyc, up_req_gnt, e_gnt); end
      if (w >= 0) begin
        checks++; if (dn_req_addr !== up_req_addr[w] || dn_req_wr !== up_req_wr[w] || dn_req_dat !== up_req_dat[w] || dn_req_dat_strb !== up_req_dat_strb[w])
          begin errors++; $display("FAIL rand_payload cyc=%0d ch=%0d got addr=%h wr=%b exp addr=%h wr=%b", cyc, w, dn_req_addr, dn_req_wr, up_req_addr[w], up_req_wr[w]); end
      end
      e_rsp = '0;
      e_rgnt = 1'b1;
      h = -1;
      if (m_q.size() > 0) begin
        h = m_q[0];
        e_rsp = dn_rsp_vld ? (NCH'(1) << h) : '0;
        e_rgnt = up_rsp_gnt[h];
      end
      checks++; if (up_rsp_vld !== e_rsp) begin errors++; $display("FAIL rand_rsp cyc=%0d got %b exp %b", cyc, up_rsp_vld, e_rsp); end
      checks++; if (dn_rsp_gnt !== e_rgnt) begin errors++; $display("FAIL rand_rgnt cyc=%0d got %b exp %b", cyc, dn_rsp_gnt, e_rgnt); end
      checks++; if (int'(outstanding) !== m_q.size()) begin errors++; $display("FAIL rand_out cyc=%0d got %0d exp %0d", cyc, outstanding, m_q.size()); end
      if (h >= 0 && dn_rsp_vld && up_rsp_gnt[h]) void'(m_q.pop_front());
      if (w >= 0 && dn_req_gnt) begin
        if (!up_req_wr[w]) m_q.push_back(w);
        pend[w] = 1'b0;
        m_lock = -1;
        m_rr = (w + 1) % NCH;
      end else if (w >= 0) begin
        m_lock = w;
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL rand_orphan got %b exp 0", err_orphan); end
    next_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    m_rr = 0;
    m_lock = -1;
    #1;
    test_reset();
    test_rr_fair();
    test_lock();
    test_qfull();
    test_backpressure();
    test_orphan_reset();
    test_fixed();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
